apb_mem_completer: RTL
======================

# apb_mem_completer

APB4 completer (slave) that responds to the existing APB master in the topAPB subsystem. It holds a word-addressed, byte-strobed register memory, inserts a parameterised number of wait states via PREADY, and flags out-of-range accesses with PSLVERR. One instance sits behind each PSEL line the master decodes.

## Interface

- ADDWIDTH, 8: width of PADDR; this is the word address seen by the completer after the master's slave-select bit is stripped.
- DATAWIDTH, 32: data width; a multiple of 8.
- DEPTH, 64: number of words implemented; valid indices are 0..DEPTH-1, with DEPTH ≤ 2^ADDWIDTH.
- WAIT_STATES, 0: number of access cycles with PREADY low before completion; range 0..15.

- PCLK  in  1  clock; all state updates on the rising edge.
- PRESETn  in  1  asynchronous, active-low reset.
- PSEL  in  1  completer selected.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDWIDTH  word index.
- PWDATA  in  DATAWIDTH  write data.
- PSTRB  in  DATAWIDTH/8  byte-lane write enables; bit i covers PWDATA[8i+7:8i].
- PREADY  out  1  transfer-complete, registered.
- PRDATA  out  DATAWIDTH  read data, registered.
- PSLVERR  out  1  error response, registered; valid only while PREADY=1.

## Operation

- FSM states:
  - IDLE: waiting for a transfer.
  - WAIT: access phase with PREADY low.
  - DONE: access phase with PREADY high.
- In IDLE, a setup edge is one where PSEL=1 and PENABLE=0. On that edge:
  - Latch PADDR, PWRITE, PWDATA and PSTRB.
  - Load the wait counter with WAIT_STATES.
  - If WAIT_STATES=0, go to DONE and raise PREADY. Otherwise go to WAIT.
- In WAIT, on each edge with PSEL=1 and PENABLE=1:
  - If the counter is 1, go to DONE and raise PREADY. The counter reaches 0.
  - Otherwise decrement the counter.
- On the edge that raises PREADY:
  - Compute err = (latched index ≥ DEPTH) and drive PSLVERR = err.
  - Read, no error: PRDATA ← mem[index].
  - Read, error: PRDATA ← 0.
  - Write: PRDATA holds its previous value.
- In DONE, the next edge is the completion edge. On that edge:
  - Write with no error: update each byte lane i with PSTRB[i]=1. Lanes with PSTRB[i]=0 keep their old contents.
  - Write with error: memory is unchanged.
  - Drop PREADY and PSLVERR, and return to IDLE.
- PSEL dropping in WAIT or DONE is a protocol violation. Required response: return to IDLE, commit nothing, drop PREADY and PSLVERR.
- PSTRB is ignored on reads. Latched PWDATA and PSTRB are used rather than live inputs.
- PRDATA holds its value between transfers.

## Timing

- Reset (asynchronous, takes effect immediately):
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - FSM returns to IDLE and the counter is cleared.
  - All memory words are cleared to 0.
  - A reset mid-transfer discards the transfer.
- The access phase lasts exactly WAIT_STATES+1 cycles. PREADY is high only in the last of these.
- Zero-wait case: PREADY is high in the first cycle PENABLE=1.
- Write visibility: a write commits on the completion edge. A read whose setup begins in the very next cycle returns the new data.
- Back-to-back transfers: a setup cycle may immediately follow the completion cycle, with PSEL staying high. No idle cycle is required.
- PRDATA and PSLVERR are stable for the whole cycle in which PREADY=1.

## Test plan

- Reset check: assert PRESETn=0, then release, then read index 5 → PREADY=1 in the first access cycle (WAIT_STATES=0), PRDATA=0x00000000, PSLVERR=0.
- Full write and readback: write 0xCAFEBABE to index 0 with PSTRB=4'b1111 → PREADY in the first access cycle; a following read of index 0 returns 0xCAFEBABE.
- Strobe merge, from reset:
  - Write 0xFFFFFFFF to index 1 with PSTRB=4'b1010 → read returns 0xFF00FF00.
  - Then write 0x00EE00EE with PSTRB=4'b0101 → read returns 0xFFEEFFEE.
- Wait states, instance with WAIT_STATES=2: write index 2 → PREADY low for 2 access cycles and high on the 3rd. The write commits only then; a later read of index 2 returns the written value.
- Error response: write 0x12345678 to index 0x50 (DEPTH=64) → PSLVERR=1 alongside PREADY; memory is unchanged. A read of index 0x50 gives PRDATA=0 and PSLVERR=1. A read of index 63 gives PSLVERR=0.
- Reset mid-transfer, WAIT_STATES=2: pull PRESETn low in the 1st access cycle of a write to index 3 → PREADY, PSLVERR and PRDATA go to 0 immediately. After release, a read of index 3 returns 0.

Source files
------------

// File: rtl/apb_mem_completer.sv
// apb_mem_completer
//
// APB4 completer holding a word-addressed, byte-strobed register memory.
// Every transfer is latched on its setup edge. The completer then holds
// PREADY low for WAIT_STATES access cycles, and raises it for exactly one
// cycle with registered PRDATA and PSLVERR. Indices at or beyond DEPTH
// complete with PSLVERR=1, and a read of such an index returns zero.
//
// Parameters:
//   ADDWIDTH    - width of PADDR (word index)
//   DATAWIDTH   - data width, a multiple of 8
//   DEPTH       - number of implemented words (<= 2**ADDWIDTH)
//   WAIT_STATES - access cycles with PREADY low before completion (0..15)
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETn  in   asynchronous active-low reset (also clears the memory)
//   PSEL     in   completer selected
//   PENABLE  in   access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   word index
//   PWDATA   in   write data
//   PSTRB    in   byte-lane write enables
//   PREADY   out  transfer complete (registered)
//   PRDATA   out  read data (registered, held between transfers)
//   PSLVERR  out  error response (registered, valid while PREADY=1)

module apb_mem_completer #(
    parameter int ADDWIDTH    = 8,
    parameter int DATAWIDTH   = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   PSEL,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [ADDWIDTH-1:0]    PADDR,
    input  logic [DATAWIDTH-1:0]   PWDATA,
    input  logic [DATAWIDTH/8-1:0] PSTRB,
    output logic                   PREADY,
    output logic [DATAWIDTH-1:0]   PRDATA,
    output logic                   PSLVERR
);

    localparam int NLANES = DATAWIDTH / 8;
    localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        WS        = 4'(WAIT_STATES);
    localparam logic [ADDWIDTH:0] DEPTH_EXT = (ADDWIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [ADDWIDTH-1:0]  addr_q;
    logic                 write_q;
    logic [DATAWIDTH-1:0] wdata_q;
    logic [NLANES-1:0]    strb_q;

    logic [DATAWIDTH-1:0] mem [DEPTH];

    logic setup, raise, complete, abort;

    logic [ADDWIDTH-1:0] acc_addr;
    logic                acc_write;
    logic                acc_err;
    logic [IDXW-1:0]     acc_idx;
    logic                commit_err;
    logic [IDXW-1:0]     commit_idx;

    // State register and wait counter.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and the per-edge control strobes for the datapath.
    // 'raise' marks the edge that puts PREADY high. 'complete' and 'abort'
    // mark the edges that end the access phase, with or without committing.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        setup    = 1'b0;
        raise    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    setup = 1'b1;
                    cnt_d = WS;
                    if (WS == 4'd0) begin
                        state_d = S_DONE;
                        raise   = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!PSEL) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (PENABLE) begin
                    if (cnt_q == 4'd1) begin
                        state_d = S_DONE;
                        cnt_d   = 4'd0;
                        raise   = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (PSEL) begin
                    complete = 1'b1;
                end else begin
                    abort = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states, PREADY rises on the setup edge itself, before
    // the latched copies are valid. In that case the response is computed
    // from the live bus instead.
    always_comb begin
        acc_addr   = setup ? PADDR : addr_q;
        acc_write  = setup ? PWRITE : write_q;
        acc_err    = ({1'b0, acc_addr} >= DEPTH_EXT);
        acc_idx    = acc_addr[IDXW-1:0];
        commit_err = ({1'b0, addr_q} >= DEPTH_EXT);
        commit_idx = addr_q[IDXW-1:0];
    end

    // Request latches, response registers and the memory itself. A write
    // commits only on the completion edge and only from the latched data.
    // An aborted transfer therefore leaves the memory untouched.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            PRDATA  <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (setup) begin
                addr_q  <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
            if (raise) begin
                PREADY  <= 1'b1;
                PSLVERR <= acc_err;
                if (!acc_write) begin
                    PRDATA <= acc_err ? '0 : mem[acc_idx];
                end
            end
            if (complete || abort) begin
                PREADY  <= 1'b0;
                PSLVERR <= 1'b0;
            end
            if (complete && write_q && !commit_err) begin
                for (int i = 0; i < NLANES; i++) begin
                    if (strb_q[i]) begin
                        mem[commit_idx][8*i +: 8] <= wdata_q[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule
